result_serializer: RTL

Converts one registered adder result (32-bit sum plus carry) into a stream of bytes for the UART transmit path. It is the downstream consumer of the adder's valid/ready result interface and the producer of bytes for the UART TX byte interface. Upstream and downstream both use the same valid/ready handshake, so any stall from the UART back-pressures the adder without losing data.

---
 rtl/result_serializer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/result_serializer.sv
// Serializes one adder result (32-bit sum plus carry) into a byte stream.
// Valid/ready on both sides; back-to-back frames without a bubble.
module result_serializer #(
    parameter bit carry_byte_p = 1'b1,
    parameter bit msb_first_p  = 1'b0
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        valid_i,
    input  logic [31:0] sum_i,
    input  logic        carry_i,
    output logic        ready_o,
    input  logic        ready_i,
    output logic [7:0]  data_o,
    output logic        valid_o
);

    localparam int unsigned SUM_W     = 32;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned NUM_BYTES = 4 + int'(carry_byte_p);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BYTES - 1);
    localparam logic [IDX_W-1:0] CARRY_IDX = IDX_W'(4);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic [BYTE_W-1:0]  data_q, data_d;
    logic               valid_q, valid_d;
    logic               last_c;

    // Pure mux: byte idx of the frame; index 4 is the carry byte.
    function automatic logic [BYTE_W-1:0] byte_sel(
        input logic [SUM_W-1:0] sum,
        input logic             carry,
        input logic [IDX_W-1:0] idx
    );
        logic [1:0]        pos;
        logic [BYTE_W-1:0] b;
        pos = msb_first_p ? ~idx[1:0] : idx[1:0];
        case (pos)
            2'd0:    b = sum[7:0];
            2'd1:    b = sum[15:8];
            2'd2:    b = sum[23:16];
            default: b = sum[31:24];
        endcase
        if (idx == CARRY_IDX) begin
            b = {7'b0, carry};
        end
        return b;
    endfunction

    assign last_c = (idx_q == LAST_IDX);

    // ready_o is combinational from ready_i so the next frame follows the last byte directly.
    assign ready_o = reset_ni & ((state_q == IDLE) | ((state_q == SEND) & last_c & ready_i));

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        data_d  = data_q;
        valid_d = valid_q;

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (valid_i) begin
                    sum_d   = sum_i;
                    carry_d = carry_i;
                    data_d  = byte_sel(sum_i, carry_i, '0);
                    idx_d   = '0;
                    valid_d = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (ready_i) begin
                    if (!last_c) begin
                        idx_d  = idx_q + IDX_W'(1);
                        data_d = byte_sel(sum_q, carry_q, idx_q + IDX_W'(1));
                    end else if (valid_i) begin
                        sum_d   = sum_i;
                        carry_d = carry_i;
                        data_d  = byte_sel(sum_i, carry_i, '0);
                        idx_d   = '0;
                    end else begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule
